// File: rtl/evr_event_decoder.sv
// Event-code decoder: per-channel trigger pulses, seconds/ticks timestamp and
// heartbeat watchdog. All outputs are registered.
module evr_event_decoder #(
  parameter int unsigned CHANNELS   = 4,
  parameter logic [31:0] HB_TIMEOUT = 32'd250000000
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [7:0]              eventCode,
  input  logic                    eventValid,
  input  logic [8*CHANNELS-1:0]   channelCodes,
  output logic [CHANNELS-1:0]     eventPulse,
  output logic [31:0]             seconds,
  output logic [31:0]             ticks,
  output logic                    timestampValid,
  output logic                    heartbeatLost
);

  localparam logic [7:0] CodeShift0  = 8'h70;
  localparam logic [7:0] CodeShift1  = 8'h71;
  localparam logic [7:0] CodeHbeat   = 8'h7A;
  localparam logic [7:0] CodeLatch   = 8'h7D;

  logic [CHANNELS-1:0] pulse_d, pulse_q;
  logic [31:0]         shift_d, shift_q;
  logic [5:0]          bit_cnt_d, bit_cnt_q;
  logic [31:0]         seconds_d, seconds_q;
  logic                ts_valid_d, ts_valid_q;
  logic [31:0]         ticks_d, ticks_q;
  logic [31:0]         hb_cnt_d, hb_cnt_q;
  logic                hb_lost_d, hb_lost_q;

  logic is_shift0, is_shift1, is_hbeat, is_latch;

  // Decode the special codes; invalid cycles decode to nothing.
  always_comb begin
    is_shift0 = eventValid && (eventCode == CodeShift0);
    is_shift1 = eventValid && (eventCode == CodeShift1);
    is_hbeat  = eventValid && (eventCode == CodeHbeat);
    is_latch  = eventValid && (eventCode == CodeLatch);
  end

  // Channel match: a zero channel code is disabled, so the null code never matches.
  always_comb begin
    pulse_d = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      pulse_d[k] = eventValid && (channelCodes[8*k +: 8] != 8'h00) &&
                   (eventCode == channelCodes[8*k +: 8]);
    end
  end

  // Seconds shift register, latch and ticks counter next-state.
  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    seconds_d  = seconds_q;
    ts_valid_d = ts_valid_q;
    ticks_d    = (ticks_q == 32'hFFFF_FFFF) ? ticks_q : ticks_q + 32'd1;
    if (is_shift0 || is_shift1) begin
      shift_d   = {shift_q[30:0], is_shift1};
      bit_cnt_d = (bit_cnt_q == 6'd63) ? bit_cnt_q : bit_cnt_q + 6'd1;
    end
    if (is_latch) begin
      // Only a complete 32-bit sequence is trusted; shift_q is left intact.
      if (bit_cnt_q == 6'd32) begin
        seconds_d  = shift_q;
        ts_valid_d = 1'b1;
      end else begin
        ts_valid_d = 1'b0;
      end
      ticks_d   = '0;
      bit_cnt_d = '0;
    end
  end

  // Heartbeat watchdog; a received heartbeat drops the alarm on the next cycle.
  always_comb begin
    if (is_hbeat) begin
      hb_cnt_d  = '0;
      hb_lost_d = 1'b0;
    end else begin
      hb_cnt_d  = (hb_cnt_q == HB_TIMEOUT) ? hb_cnt_q : hb_cnt_q + 32'd1;
      hb_lost_d = (hb_cnt_q == HB_TIMEOUT);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pulse_q    <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      seconds_q  <= '0;
      ts_valid_q <= 1'b0;
      ticks_q    <= '0;
      hb_cnt_q   <= '0;
      hb_lost_q  <= 1'b0;
    end else begin
      pulse_q    <= pulse_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      seconds_q  <= seconds_d;
      ts_valid_q <= ts_valid_d;
      ticks_q    <= ticks_d;
      hb_cnt_q   <= hb_cnt_d;
      hb_lost_q  <= hb_lost_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    eventPulse     = pulse_q;
    seconds        = seconds_q;
    ticks          = ticks_q;
    timestampValid = ts_valid_q;
    heartbeatLost  = hb_lost_q;
  end

endmodule

// File: tb/tb_evr_event_decoder.sv
// Self-checking bench for evr_event_decoder: channel-match vector table plus
// directed timestamp, heartbeat and reset sequences.
module tb_evr_event_decoder;

  logic        Clock;
  logic        Reset;
  logic [7:0]  eventCode;
  logic        eventValid;
  logic [31:0] channelCodes;
  logic [3:0]  eventPulse;
  logic [31:0] seconds;
  logic [31:0] ticks;
  logic        timestampValid;
  logic        heartbeatLost;

  int checks = 0;
  int errors = 0;

  evr_event_decoder #(
    .CHANNELS  (4),
    .HB_TIMEOUT(32'd100)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .eventCode     (eventCode),
    .eventValid    (eventValid),
    .channelCodes  (channelCodes),
    .eventPulse    (eventPulse),
    .seconds       (seconds),
    .ticks         (ticks),
    .timestampValid(timestampValid),
    .heartbeatLost (heartbeatLost)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  typedef struct {
    logic       v;
    logic [7:0] code;
    logic [3:0] exp_pulse;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present one input cycle; on return the outputs reflect that cycle's sample.
  task automatic cyc(input logic v, input logic [7:0] c);
    eventValid = v;
    eventCode  = c;
    @(posedge Clock);
    #1;
  endtask

  // Shift the low n bits of val MSB-first.
  task automatic send_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) cyc(1'b1, val[i] ? 8'h71 : 8'h70);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " pulse"}, {28'd0, eventPulse}, 32'd0);
    chk({tag, " seconds"}, seconds, 32'd0);
    chk({tag, " ticks"}, ticks, 32'd0);
    chk({tag, " tsvalid"}, {31'd0, timestampValid}, 32'd0);
    chk({tag, " hblost"}, {31'd0, heartbeatLost}, 32'd0);
  endtask

  initial begin
    int lost_early;

    // ch3=0x10, ch2=0x00, ch1=0x2A, ch0=0x2A
    vecs[0] = '{1'b1, 8'h2A, 4'b0011};
    vecs[1] = '{1'b1, 8'h2A, 4'b0011};  // back-to-back identical code
    vecs[2] = '{1'b0, 8'h2A, 4'b0000};  // not valid
    vecs[3] = '{1'b0, 8'h00, 4'b0000};
    vecs[4] = '{1'b1, 8'h00, 4'b0000};  // null code, ch2 disabled
    vecs[5] = '{1'b1, 8'h10, 4'b1000};
    vecs[6] = '{1'b1, 8'h11, 4'b0000};
    vecs[7] = '{1'b1, 8'h7D, 4'b0000};
    vecs[8] = '{1'b0, 8'h00, 4'b0000};

    Reset        = 1'b1;
    eventValid   = 1'b0;
    eventCode    = 8'h00;
    channelCodes = {8'h10, 8'h00, 8'h2A, 8'h2A};

    // Reset state, with a matching event held during reset.
    cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h2A);
    chk_reset_outputs("reset");
    Reset = 1'b0;

    // Channel-match table.
    for (int i = 0; i < 9; i++) begin
      cyc(vecs[i].v, vecs[i].code);
      chk($sformatf("vec%0d pulse", i), {28'd0, eventPulse}, {28'd0, vecs[i].exp_pulse});
    end

    // Full 32-bit timestamp.
    send_bits(32'h12345678, 32);
    cyc(1'b1, 8'h7D);
    chk("ts32 seconds", seconds, 32'h12345678);
    chk("ts32 tsvalid", {31'd0, timestampValid}, 32'd1);
    chk("ts32 ticks0", ticks, 32'd0);
    cyc(1'b0, 8'h00);
    chk("ts32 ticks1", ticks, 32'd1);
    cyc(1'b0, 8'h00);
    chk("ts32 ticks2", ticks, 32'd2);

    // Short sequence rejected.
    send_bits(32'hDEADBEEF, 31);
    cyc(1'b1, 8'h7D);
    chk("ts31 seconds", seconds, 32'h12345678);
    chk("ts31 tsvalid", {31'd0, timestampValid}, 32'd0);
    chk("ts31 ticks0", ticks, 32'd0);

    // Long sequence rejected.
    send_bits(32'hDEADBEEF, 32);
    send_bits(32'h1, 1);
    cyc(1'b1, 8'h7D);
    chk("ts33 seconds", seconds, 32'h12345678);
    chk("ts33 tsvalid", {31'd0, timestampValid}, 32'd0);

    // ch0 on the latch code; invalid shift codes in the stream are ignored.
    channelCodes = {8'h10, 8'h00, 8'h2A, 8'h7D};
    send_bits(32'hCAFE0000 >> 16, 16);
    cyc(1'b0, 8'h71);
    cyc(1'b0, 8'h70);
    send_bits(32'h0000F00D, 16);
    cyc(1'b1, 8'h7D);
    chk("latchch pulse", {28'd0, eventPulse}, 32'h1);
    chk("latchch seconds", seconds, 32'hCAFEF00D);
    chk("latchch tsvalid", {31'd0, timestampValid}, 32'd1);
    cyc(1'b0, 8'h00);
    chk("latchch pulse off", {28'd0, eventPulse}, 32'h0);

    // Reset mid-shift discards the partial seconds.
    send_bits(32'h000ABCDE, 20);
    Reset = 1'b1;
    cyc(1'b0, 8'h00);
    chk_reset_outputs("midreset");
    Reset = 1'b0;
    send_bits(32'h00000ABC, 12);
    cyc(1'b1, 8'h7D);
    chk("post-reset 12b tsvalid", {31'd0, timestampValid}, 32'd0);
    chk("post-reset 12b seconds", seconds, 32'd0);
    send_bits(32'h0F0F1234, 32);
    cyc(1'b1, 8'h7D);
    chk("post-reset 32b tsvalid", {31'd0, timestampValid}, 32'd1);
    chk("post-reset 32b seconds", seconds, 32'h0F0F1234);

    // Heartbeat watchdog with HB_TIMEOUT = 100.
    Reset = 1'b1;
    cyc(1'b0, 8'h00);
    Reset = 1'b0;
    lost_early = 0;
    for (int i = 1; i <= 100; i++) begin
      cyc(1'b0, 8'h00);
      if (heartbeatLost !== 1'b0) lost_early++;
    end
    chk("hb quiet 100 cycles", lost_early, 32'd0);
    cyc(1'b0, 8'h00);
    chk("hb lost at 101", {31'd0, heartbeatLost}, 32'd1);
    cyc(1'b0, 8'h00);
    chk("hb lost held", {31'd0, heartbeatLost}, 32'd1);
    cyc(1'b0, 8'h7A);
    chk("hb invalid 7A ignored", {31'd0, heartbeatLost}, 32'd1);
    cyc(1'b1, 8'h7A);
    chk("hb cleared", {31'd0, heartbeatLost}, 32'd0);
    cyc(1'b0, 8'h00);
    chk("hb stays clear", {31'd0, heartbeatLost}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/evr_event_decoder.md
# evr_event_decoder

Decodes the received event-code stream into per-channel single-cycle trigger requests and maintains the event-system timestamp (seconds and ticks) plus a heartbeat watchdog. Sits directly between the event-link receiver (8-bit code plus valid strobe) and the bank of delay/width trigger-generator channels. Each channel's `eventPulse` bit drives that channel's event input.

## Interface
Parameters:
- `CHANNELS`, 4: number of trigger channels decoded.
- `HB_TIMEOUT`, 32'd250000000: Clock cycles without heartbeat before `heartbeatLost` asserts.

Ports:
- `Clock`  in  1  single system clock; all logic on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `eventCode`  in  8  received event code.
- `eventValid`  in  1  `eventCode` is a new event this cycle.
- `channelCodes`  in  8*CHANNELS  programmed code per channel; channel k uses bits [8k+7:8k].
- `eventPulse`  out  CHANNELS  one-cycle pulse per matching channel.
- `seconds`  out  32  latched seconds value.
- `ticks`  out  32  Clock cycles since last seconds latch.
- `timestampValid`  out  1  last 0x7D latch was preceded by exactly 32 shifted bits.
- `heartbeatLost`  out  1  no 0x7A received for `HB_TIMEOUT` cycles.

## Operation
- Events are sampled only when `eventValid`=1. Otherwise `eventCode` is ignored entirely.
- Code 0x00 is the null code. It never matches, never shifts, and never latches.
- Channel match:
  - Channel k pulses when `eventCode` == `channelCodes[k]` and `channelCodes[k]` != 0.
  - Several channels may pulse together.
  - Matching is independent of the special codes below: a channel programmed to 0x7D pulses and the latch also happens.
  - `channelCodes` is compared as presented on the sampling cycle; changing it mid-stream needs no handshake.
- Seconds shift register (32 bits, `shiftReg`) with a 6-bit `bitCount`:
  - Code 0x70: `shiftReg` <= {`shiftReg`[30:0], 0}.
  - Code 0x71: `shiftReg` <= {`shiftReg`[30:0], 1}.
  - Both codes increment `bitCount`, saturating at 63.
- Code 0x7D (seconds latch):
  - If `bitCount`==32: `seconds` <= `shiftReg` and `timestampValid` <= 1.
  - Otherwise: `seconds` is unchanged and `timestampValid` <= 0.
  - In both cases `ticks` <= 0 and `bitCount` <= 0. `shiftReg` is not cleared.
- Ticks:
  - Increments by 1 every cycle and saturates at 32'hFFFFFFFF (no wrap).
  - Clear on 0x7D has priority over the increment.
- Heartbeat:
  - `hbCount` (32 bits) clears on code 0x7A.
  - Otherwise it increments, saturating at `HB_TIMEOUT`.
  - `heartbeatLost` = (`hbCount` == `HB_TIMEOUT`), registered.
  - A 0x7A clears `heartbeatLost` on the next cycle.
- Reset values:
  - `eventPulse`=0, `seconds`=0, `ticks`=0, `timestampValid`=0, `heartbeatLost`=0.
  - `shiftReg`=0, `bitCount`=0, `hbCount`=0.
- Reset mid-shift discards partial seconds. The next 0x7D then requires a full 32 new bits to set `timestampValid`.

## Timing
- Latency, cycle N = `eventValid`/`eventCode` sampled:
  - `eventPulse` asserts in cycle N+1 for exactly one cycle.
  - `seconds`/`timestampValid`/`ticks`=0 update at N+1.
  - `shiftReg`/`bitCount` update at N+1.
- Back-to-back events (valid every cycle) are supported with no gaps. Identical consecutive codes give consecutive pulses, each one cycle wide.
- Ticks: value 0 at N+1 after a 0x7D, 1 at N+2, and so on.
- Heartbeat:
  - With no 0x7A since reset, `heartbeatLost` asserts on the first cycle after `hbCount` reaches `HB_TIMEOUT`, i.e. `HB_TIMEOUT`+1 cycles after Reset deasserts.
  - It stays asserted until the cycle after a 0x7A.
- No internal state machine beyond the counters. Outputs are all registered; no combinational input-to-output paths.

## Test plan
- Codes ch0=0x2A, ch1=0x2A, ch2=0x00, ch3=0x10. Send 0x2A with valid. Expect `eventPulse`=4'b0011 for exactly one cycle, one cycle later. Send 0x00 and 0x2A with valid=0. Expect no pulse.
- Send 32 bits of 0x12345678 MSB-first via 0x70/0x71, then 0x7D. Expect `seconds`=0x12345678, `timestampValid`=1, `ticks`=0 next cycle, 1 the cycle after.
- Send 31 bits then 0x7D. Expect `seconds` unchanged and `timestampValid`=0. Send 33 bits then 0x7D. Expect the same response.
- Use `HB_TIMEOUT`=100. Hold no events: `heartbeatLost` stays 0 for 100 cycles after reset, then 1. Send 0x7A: `heartbeatLost`=0 the next cycle.
- Program ch0=0x7D and send a valid timestamp sequence. Expect the ch0 pulse and the seconds latch on the same cycle. Assert Reset mid-shift: all outputs go to their reset values, and `timestampValid` requires a fresh 32-bit sequence.
